// File: rtl/color_sequencer_if.sv
`default_nettype none
// ============================================================================
// color_sequencer_if : button inputs and colour/LED outputs of color_sequencer
// Revision 1.0
// ============================================================================
interface color_sequencer_if;
  logic       sw1;
  logic       sw2;
  logic [2:0] color;
  logic       auto_mode;
  logic       led_r;
  logic       led_g;
  logic       led_b;

  modport master (
    output sw1, sw2,
    input  color, auto_mode, led_r, led_g, led_b
  );

  modport slave (
    input  sw1, sw2,
    output color, auto_mode, led_r, led_g, led_b
  );
endinterface
`default_nettype wire

// File: rtl/color_sequencer.sv
`default_nettype none
// ============================================================================
// color_sequencer : debounced buttons step a 3-bit colour, manually or on a
//                   dwell timer, driving PWM-gated RGB LEDs
// Revision 1.0
// ============================================================================
module color_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DWELL_CYCLES    = 16,
  parameter int PWM_BITS        = 4,
  parameter int DUTY            = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  color_sequencer_if.slave bus
);

  localparam int C_DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int C_DW_W = $clog2(DWELL_CYCLES);
  localparam logic [C_DB_W-1:0]   C_DB_LAST    = C_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [C_DW_W-1:0]   C_DWELL_LAST = C_DW_W'(DWELL_CYCLES - 1);
  localparam logic [PWM_BITS:0]   C_DUTY       = (PWM_BITS + 1)'(DUTY);

  localparam logic [0:0] S_MANUAL = 1'b0;
  localparam logic [0:0] S_AUTO   = 1'b1;

  logic [1:0]          w_pin;
  logic [1:0]          w_press;
  logic [0:0]          r_state;
  logic [0:0]          w_state_next;
  logic                w_auto;
  logic                w_tick;
  logic [2:0]          r_color;
  logic [C_DW_W-1:0]   r_dwell;
  logic [PWM_BITS-1:0] r_pwm;
  logic                w_pwm_on;
  logic                r_led_r;
  logic                r_led_g;
  logic                r_led_b;

  assign w_pin = {bus.sw2, bus.sw1};

  // index 0 = SW1 (mode), index 1 = SW2 (step)
  for (genvar i = 0; i < 2; i++) begin : g_sw
    logic              r_sync1;
    logic              r_sync2;
    logic              r_level;
    logic              r_level_d;
    logic [C_DB_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1   <= 1'b0;
        r_sync2   <= 1'b0;
        r_level   <= 1'b0;
        r_level_d <= 1'b0;
        r_cnt     <= '0;
      end else begin
        r_sync1   <= w_pin[i];
        r_sync2   <= r_sync1;
        r_level_d <= r_level;
        if (r_sync2 == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == C_DB_LAST) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + C_DB_W'(1);
        end
      end
    end

    assign w_press[i] = r_level & ~r_level_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_MANUAL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_press[0]) begin
      w_state_next = (r_state == S_MANUAL) ? S_AUTO : S_MANUAL;
    end
  end

  always_comb begin
    w_auto = (r_state == S_AUTO);
  end

  assign w_tick = w_auto && (r_dwell == C_DWELL_LAST);

  // a step press and a dwell wrap in the same cycle still advance only once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_color <= 3'd0;
      r_dwell <= '0;
    end else begin
      if (w_press[1] || w_tick) begin
        r_color <= r_color + 3'd1;
      end
      if (w_press[0] || w_press[1] || !w_auto || w_tick) begin
        r_dwell <= '0;
      end else begin
        r_dwell <= r_dwell + C_DW_W'(1);
      end
    end
  end

  assign w_pwm_on = ({1'b0, r_pwm} < C_DUTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm   <= '0;
      r_led_r <= 1'b0;
      r_led_g <= 1'b0;
      r_led_b <= 1'b0;
    end else begin
      r_pwm   <= r_pwm + PWM_BITS'(1);
      r_led_r <= r_color[2] & w_pwm_on;
      r_led_g <= r_color[1] & w_pwm_on;
      r_led_b <= r_color[0] & w_pwm_on;
    end
  end

  assign bus.color     = r_color;
  assign bus.auto_mode = w_auto;
  assign bus.led_r     = r_led_r;
  assign bus.led_g     = r_led_g;
  assign bus.led_b     = r_led_b;

endmodule
`default_nettype wire
